dec_2to4_reg: RTL and testbench

//   Registered 2-to-4 line decoder with one-hot outputs.
//   Two select bits (b = MSB, a = LSB) select exactly one of y0..y3 while enabled.

---
 rtl/dec_2to4_reg_if.sv | 15 +
 rtl/dec_2to4_reg.sv | 54 +++++
 tb/tb_dec_2to4_reg.sv | 111 +++++++++++
 3 files changed

// File: rtl/dec_2to4_reg_if.sv
// Decoder bus: select/enable inputs and the four decoded lines plus valid.
// The master drives en/a/b and the slave (the decoder) drives the outputs.
interface dec_2to4_reg_if;
  logic en;
  logic a;
  logic b;
  logic y0;
  logic y1;
  logic y2;
  logic y3;
  logic valid;

  modport master (output en, a, b, input y0, y1, y2, y3, valid);
  modport slave  (input en, a, b, output y0, y1, y2, y3, valid);
endinterface

// File: rtl/dec_2to4_reg.sv
// 2-to-4 one-hot decoder with an optional output register and selectable output polarity.
// When the output register is bypassed, the outputs are combinational and rst has no effect on them.
module dec_2to4_reg #(
  parameter bit REGISTERED = 1'b1,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic           clk,
  input  logic           rst,
  dec_2to4_reg_if.slave  bus
);

  logic [3:0] dec_c;
  logic [3:0] y_act;
  logic       valid_act;

  always_comb begin
    dec_c = 4'b0000;
    if (bus.en) dec_c[{bus.b, bus.a}] = 1'b1;
  end

  // Decode is kept active-high internally; polarity is applied only at the pins.
  generate
    if (REGISTERED) begin : g_reg
      logic [3:0] y_d;
      logic [3:0] y_q;
      logic       valid_d;
      logic       valid_q;

      always_comb begin
        y_d     = dec_c;
        valid_d = bus.en;
        if (rst) begin
          y_d     = 4'b0000;
          valid_d = 1'b0;
        end
      end

      always_ff @(posedge clk) begin
        y_q     <= y_d;
        valid_q <= valid_d;
      end

      assign y_act     = y_q;
      assign valid_act = valid_q;
    end else begin : g_comb
      assign y_act     = dec_c;
      assign valid_act = bus.en;
    end
  endgenerate

  assign {bus.y3, bus.y2, bus.y1, bus.y0} = ACTIVE_LOW ? ~y_act : y_act;
  assign bus.valid = valid_act;

endmodule

// File: tb/tb_dec_2to4_reg.sv
// Bench for dec_2to4_reg: registered active-high, registered active-low and combinational
// instances driven in parallel and compared against a behavioural decode model.
module tb_dec_2to4_reg;

  logic clk;
  logic rst;
  int   pass_cnt;
  int   total_cnt;

  logic [3:0] exp_y;
  logic       exp_v;

  dec_2to4_reg_if bus_r ();
  dec_2to4_reg_if bus_l ();
  dec_2to4_reg_if bus_c ();

  dec_2to4_reg #(.REGISTERED(1'b1), .ACTIVE_LOW(1'b0)) u_reg  (.clk(clk), .rst(rst), .bus(bus_r));
  dec_2to4_reg #(.REGISTERED(1'b1), .ACTIVE_LOW(1'b1)) u_low  (.clk(clk), .rst(rst), .bus(bus_l));
  dec_2to4_reg #(.REGISTERED(1'b0), .ACTIVE_LOW(1'b0)) u_comb (.clk(clk), .rst(rst), .bus(bus_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference decode: output index equal to the select value is active when enabled.
  function automatic logic [3:0] ref_dec(input logic e, input logic [1:0] s);
    logic [3:0] r;
    r = 4'd0;
    if (e) r = 4'(1 << s);
    return r;
  endfunction

  task automatic check(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
  endtask

  task automatic drive(input logic e, input logic [1:0] s);
    bus_r.en = e; bus_r.b = s[1]; bus_r.a = s[0];
    bus_l.en = e; bus_l.b = s[1]; bus_l.a = s[0];
    bus_c.en = e; bus_c.b = s[1]; bus_c.a = s[0];
  endtask

  task automatic check_comb(input string tag, input logic e, input logic [1:0] s);
    check(tag, {bus_c.valid, bus_c.y3, bus_c.y2, bus_c.y1, bus_c.y0}, {e, ref_dec(e, s)});
  endtask

  task automatic check_regs(input string tag);
    check({tag, "_hi"}, {bus_r.valid, bus_r.y3, bus_r.y2, bus_r.y1, bus_r.y0}, {exp_v, exp_y});
    check({tag, "_lo"}, {bus_l.valid, bus_l.y3, bus_l.y2, bus_l.y1, bus_l.y0}, {exp_v, ~exp_y});
  endtask

  // One clock: inputs applied at negedge, registered outputs checked after the edge,
  // then inputs scrambled mid-cycle to confirm the registers hold and the bypass tracks.
  task automatic step(input string tag, input logic r, input logic e, input logic [1:0] s);
    logic       e2;
    logic [1:0] s2;
    @(negedge clk);
    rst = r;
    drive(e, s);
    #1 check_comb({tag, "_comb"}, e, s);
    @(posedge clk);
    exp_y = r ? 4'd0 : ref_dec(e, s);
    exp_v = r ? 1'b0 : e;
    #1 check_regs(tag);
    e2 = 1'($urandom_range(0, 1));
    s2 = 2'($urandom_range(0, 3));
    drive(e2, s2);
    #1;
    check_regs({tag, "_hold"});
    check_comb({tag, "_trk"}, e2, s2);
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    exp_y     = 4'd0;
    exp_v     = 1'b0;
    rst       = 1'b1;
    drive(1'b1, 2'b11);

    step("rst0", 1'b1, 1'b1, 2'b11);
    step("rst1", 1'b1, 1'b1, 2'b11);
    step("rel_y3", 1'b0, 1'b1, 2'b11);

    for (int i = 0; i < 4; i++) step("sweep", 1'b0, 1'b1, 2'(i));

    step("dis", 1'b0, 1'b0, 2'(($urandom_range(0, 3))));
    step("dis2", 1'b0, 1'b0, 2'b01);
    step("reen_y2", 1'b0, 1'b1, 2'b10);

    step("y1_on", 1'b0, 1'b1, 2'b01);
    step("rst_mid", 1'b1, 1'b1, 2'b01);
    step("y1_back", 1'b0, 1'b1, 2'b01);

    for (int i = 0; i < 200; i++)
      step("rand", ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));

    // Bypass instance: several select changes within one clock phase.
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 2'(3 - i));
      #1 check_comb("comb_toggle", 1'b1, 2'(3 - i));
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
